// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA framebuffer write controller
package vga_pkg;
    localparam int FB_DEPTH = 49152;
    localparam int FB_AW = 16;
    localparam logic [3:0] REG_FILL_ADDR = 4'h0;
    localparam logic [3:0] REG_FILL_LEN = 4'h4;
    localparam logic [3:0] REG_FILL_COLOR = 4'h8;
    localparam logic [3:0] REG_CMD = 4'hC;
    typedef enum logic {ST_IDLE, ST_RUN} fill_st_t;
endpackage

// File: rtl/vga_fb_arb.sv
// vga_fb_arb: 2-input round-robin grant for the shared framebuffer write port
// Ports: clk, rst; i_req_cpu/i_req_fill requests in; o_gnt_cpu/o_gnt_fill one-hot grants out
module vga_fb_arb (
    input  logic clk,
    input  logic rst,
    input  logic i_req_cpu,
    input  logic i_req_fill,
    output logic o_gnt_cpu,
    output logic o_gnt_fill
);
    import vga_pkg::*;
    // resets to "fill went last" so the CPU wins the first contended cycle
    logic r_last_fill;
    always_comb begin
        o_gnt_cpu = i_req_cpu && (!i_req_fill || r_last_fill);
        o_gnt_fill = i_req_fill && !o_gnt_cpu;
    end
    always_ff @(posedge clk) begin
        if (rst) r_last_fill <= 1'b1;
        else if (o_gnt_cpu || o_gnt_fill) r_last_fill <= o_gnt_fill;
    end
endmodule

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: iomem-to-BRAM framebuffer write controller with byte serialiser and fill engine
// Ports: clk, rst (sync, active high); iomem_* picosoc bus slave; fb_* registered BRAM port A;
// fill_busy fill engine running. Fill engine, FILL_* registers and arbiter exist only with
// VGA_FB_FILL_EN defined; otherwise the CPU owns the port and registers read 0.
module vga_fb_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h0300_0000,
    parameter int FB_DEPTH = vga_pkg::FB_DEPTH,
    parameter int FB_AW = vga_pkg::FB_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic             fb_en,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_din,
    output logic             fill_busy
);
    import vga_pkg::*;
    localparam logic [31:0] REG_BASE = ADDR_BASE + 32'h0001_0000;
    logic [31:0] w_off, w_data, w_reg_q;
    logic w_in_fb, w_in_reg, w_dec, w_req_cpu, w_gnt_cpu, w_gnt_fill;
    logic [3:0] w_lane_ok, w_mask, w_rem, w_mask_nxt;
    logic [1:0] w_lane;
    logic [FB_AW-3:0] w_word;
    logic [7:0] w_byte, w_fill_din;
    logic [FB_AW-1:0] w_fill_addr;
    logic [3:0] r_mask;
    logic [FB_AW-3:0] r_word;
    logic [31:0] r_wdata, r_rdata;
    logic r_ready;
    // r_mask holds the lanes still to write; nonzero means a store is in progress.
    // Lane 0 of a new store is offered to the arbiter straight from the bus in the decode cycle.
    always_comb begin
        w_off = iomem_addr - ADDR_BASE;
        w_in_fb = iomem_addr >= ADDR_BASE && w_off < 32'(FB_DEPTH);
        w_in_reg = iomem_addr[31:4] == REG_BASE[31:4];
        w_dec = iomem_valid && r_mask == 4'b0 && !r_ready && (w_in_fb || w_in_reg);
        for (int i = 0; i < 4; i++)
            w_lane_ok[i] = iomem_wstrb[i] && ({w_off[31:2], 2'b00} + 32'(i)) < 32'(FB_DEPTH);
        w_mask = |r_mask ? r_mask : (w_dec && w_in_fb ? w_lane_ok : 4'b0);
        w_lane = w_mask[0] ? 2'd0 : w_mask[1] ? 2'd1 : w_mask[2] ? 2'd2 : 2'd3;
        w_rem = w_mask & ~(4'b0001 << w_lane);
        w_req_cpu = |w_mask;
        w_word = |r_mask ? r_word : w_off[FB_AW-1:2];
        w_data = |r_mask ? r_wdata : iomem_wdata;
        w_byte = w_data[8*w_lane +: 8];
    end
    assign w_mask_nxt = w_gnt_cpu ? w_rem : w_mask;
    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_word <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            fb_en <= 1'b0;
            fb_we <= 1'b0;
            fb_addr <= '0;
            fb_din <= '0;
        end else begin
            r_mask <= w_mask_nxt;
            r_ready <= (w_dec || |r_mask) && w_mask_nxt == 4'b0;
            r_rdata <= (w_dec && w_in_reg && iomem_wstrb == 4'b0) ? w_reg_q : 32'b0;
            if (w_dec) begin
                r_word <= w_off[FB_AW-1:2];
                r_wdata <= iomem_wdata;
            end
            fb_en <= w_gnt_cpu || w_gnt_fill;
            fb_we <= w_gnt_cpu || w_gnt_fill;
            if (w_gnt_cpu || w_gnt_fill) begin
                fb_addr <= w_gnt_cpu ? {w_word, w_lane} : w_fill_addr;
                fb_din <= w_gnt_cpu ? w_byte : w_fill_din;
            end
        end
    end
`ifdef VGA_FB_FILL_EN
    fill_st_t r_state;
    logic [15:0] r_fill_addr, r_fill_len, r_cnt;
    logic [7:0] r_fill_color, r_col;
    logic [FB_AW-1:0] r_cur;
    logic r_done;
    logic [3:0] w_reg_off;
    logic w_reg_wr, w_start, w_last;
    vga_fb_arb u_arb (
        .clk(clk),
        .rst(rst),
        .i_req_cpu(w_req_cpu),
        .i_req_fill(r_state == ST_RUN),
        .o_gnt_cpu(w_gnt_cpu),
        .o_gnt_fill(w_gnt_fill)
    );
    assign w_reg_off = {iomem_addr[3:2], 2'b00};
    assign w_reg_wr = w_dec && w_in_reg && |iomem_wstrb;
    assign w_start = w_reg_wr && w_reg_off == REG_CMD && iomem_wdata[0];
    // stop on the last byte or before stepping past the end of the buffer
    assign w_last = r_cnt == 16'd1 || 32'(r_cur) + 32'd1 >= 32'(FB_DEPTH);
    assign w_fill_addr = r_cur;
    assign w_fill_din = r_col;
    assign fill_busy = r_state == ST_RUN;
    assign w_reg_q = w_reg_off == REG_FILL_ADDR ? {16'b0, r_fill_addr} :
                     w_reg_off == REG_FILL_LEN ? {16'b0, r_fill_len} :
                     w_reg_off == REG_FILL_COLOR ? {24'b0, r_fill_color} : {30'b0, r_done, fill_busy};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fill_addr <= '0;
            r_fill_len <= '0;
            r_fill_color <= '0;
            r_cnt <= '0;
            r_col <= '0;
            r_cur <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_reg_wr && w_reg_off == REG_FILL_ADDR) r_fill_addr <= iomem_wdata[15:0];
            if (w_reg_wr && w_reg_off == REG_FILL_LEN) r_fill_len <= iomem_wdata[15:0];
            if (w_reg_wr && w_reg_off == REG_FILL_COLOR) r_fill_color <= iomem_wdata[7:0];
            if (w_reg_wr && w_reg_off == REG_CMD) r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_start && r_fill_len != 16'd0) begin
                    r_state <= ST_RUN;
                    r_cur <= FB_AW'(r_fill_addr);
                    r_cnt <= r_fill_len;
                    r_col <= r_fill_color;
                end else if (w_start) r_done <= 1'b1;
            end else if (w_gnt_fill) begin
                r_cur <= r_cur + 1'b1;
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_done <= 1'b1;
                end
            end
        end
    end
`else
    assign w_gnt_cpu = w_req_cpu;
    assign w_gnt_fill = 1'b0;
    assign w_fill_addr = '0;
    assign w_fill_din = '0;
    assign fill_busy = 1'b0;
    assign w_reg_q = '0;
`endif
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: directed self-checking bench for vga_fb_ctrl
module tb_vga_fb_ctrl;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] REGB = 32'h0301_0000;
    logic clk = 1'b0, rst = 1'b1, iomem_valid = 1'b0, iomem_ready, fb_en, fb_we, fill_busy;
    logic [3:0] iomem_wstrb = 4'b0;
    logic [31:0] iomem_addr = 32'b0, iomem_wdata = 32'b0, iomem_rdata;
    logic [15:0] fb_addr;
    logic [7:0] fb_din;
    int total = 0, bad = 0, cyc = 0, busy_cyc = 0;
    logic [15:0] log_a[$];
    logic [7:0] log_d[$];
    int log_c[$];
    vga_fb_ctrl dut (
        .clk(clk), .rst(rst),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .fill_busy(fill_busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fb_en && fb_we) begin
            log_a.push_back(fb_addr);
            log_d.push_back(fb_din);
            log_c.push_back(cyc);
        end
        if (fill_busy) busy_cyc++;
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output int n);
        iomem_valid = 1'b1;
        iomem_addr = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!iomem_ready && n < 50);
        chk("bus_ready", {31'b0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        step();
    endtask
    task automatic wait_idle();
        int n = 0;
        while (fill_busy && n < 200) begin
            step();
            n++;
        end
        chk("fill_idle", {31'b0, fill_busy}, 32'd0);
        step();
    endtask
    initial begin
        logic [31:0] rd, w;
        int n, s0, b0;
        logic [15:0] exp_a[12];
        logic [7:0] exp_d[12];
        repeat (3) step();
        chk("rst_ready", {31'b0, iomem_ready}, 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_fb_en", {31'b0, fb_en}, 0);
        chk("rst_fb_we", {31'b0, fb_we}, 0);
        chk("rst_fb_addr", {16'b0, fb_addr}, 0);
        chk("rst_fb_din", {24'b0, fb_din}, 0);
        chk("rst_busy", {31'b0, fill_busy}, 0);
        rst = 1'b0;
        step();
        bus(REGB + 32'hC, 4'h0, 32'h0, rd, n);
        chk("status_after_rst", rd, 0);
        chk("reg_rd_latency", n, 1);
        s0 = log_a.size();
        w = 32'hAABBCCDD;
        bus(BASE + 32'h100, 4'hF, w, rd, n);
        chk("st4_latency", n, 4);
        chk("st4_count", log_a.size() - s0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("st4_addr", {16'b0, log_a[s0+i]}, 32'h100 + i);
            chk("st4_data", {24'b0, log_d[s0+i]}, {24'b0, w[8*i +: 8]});
        end
        chk("st4_consecutive", log_c[s0+3] - log_c[s0], 3);
        s0 = log_a.size();
        bus(BASE + 32'hBFFC, 4'b0101, 32'h11223344, rd, n);
        chk("st2_latency", n, 2);
        chk("st2_count", log_a.size() - s0, 2);
        chk("st2_addr0", {16'b0, log_a[s0]}, 32'hBFFC);
        chk("st2_data0", {24'b0, log_d[s0]}, 32'h44);
        chk("st2_addr1", {16'b0, log_a[s0+1]}, 32'hBFFE);
        chk("st2_data1", {24'b0, log_d[s0+1]}, 32'h22);
        s0 = log_a.size();
        bus(BASE + 32'h100, 4'h0, 32'h0, rd, n);
        chk("fbrd_data", rd, 0);
        chk("fbrd_latency", n, 1);
        chk("fbrd_nowrite", log_a.size() - s0, 0);
        s0 = log_a.size();
        iomem_valid = 1'b1;
        iomem_addr = BASE + 32'hC000;
        iomem_wstrb = 4'hF;
        repeat (4) step();
        chk("unmapped_noready", {31'b0, iomem_ready}, 0);
        chk("unmapped_nowrite", log_a.size() - s0, 0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        step();
`ifdef VGA_FB_FILL_EN
        bus(REGB + 32'h8, 4'hF, 32'hFFFFFF1C, rd, n);
        bus(REGB + 32'h8, 4'h0, 32'h0, rd, n);
        chk("color_rdback", rd, 32'h1C);
        bus(REGB + 32'h0, 4'hF, 32'h10, rd, n);
        bus(REGB + 32'h4, 4'hF, 32'h5, rd, n);
        b0 = busy_cyc;
        s0 = log_a.size();
        bus(REGB + 32'hC, 4'hF, 32'h1, rd, n);
        wait_idle();
        chk("fill5_busy_cycles", busy_cyc - b0, 5);
        chk("fill5_count", log_a.size() - s0, 5);
        for (int i = 0; i < 5; i++) begin
            chk("fill5_addr", {16'b0, log_a[s0+i]}, 32'h10 + i);
            chk("fill5_data", {24'b0, log_d[s0+i]}, 32'h1C);
        end
        bus(REGB + 32'hC, 4'h0, 32'h0, rd, n);
        chk("fill5_status", rd, 32'h2);
        bus(REGB + 32'h0, 4'hF, 32'hBFFE, rd, n);
        bus(REGB + 32'h4, 4'hF, 32'd10, rd, n);
        b0 = busy_cyc;
        s0 = log_a.size();
        bus(REGB + 32'hC, 4'hF, 32'h1, rd, n);
        wait_idle();
        chk("clamp_busy_cycles", busy_cyc - b0, 2);
        chk("clamp_count", log_a.size() - s0, 2);
        chk("clamp_addr0", {16'b0, log_a[s0]}, 32'hBFFE);
        chk("clamp_addr1", {16'b0, log_a[s0+1]}, 32'hBFFF);
        chk("clamp_data", {24'b0, log_d[s0+1]}, 32'h1C);
        bus(REGB + 32'hC, 4'h0, 32'h0, rd, n);
        chk("clamp_status", rd, 32'h2);
        bus(REGB + 32'hC, 4'hF, 32'h0, rd, n);
        bus(REGB + 32'hC, 4'h0, 32'h0, rd, n);
        chk("done_cleared", rd, 32'h0);
        exp_a = '{16'h200, 16'h300, 16'h201, 16'h301, 16'h202, 16'h302,
                  16'h203, 16'h303, 16'h204, 16'h205, 16'h206, 16'h207};
        exp_d = '{8'h55, 8'h01, 8'h55, 8'h02, 8'h55, 8'h03, 8'h55, 8'h04, 8'h55, 8'h55, 8'h55, 8'h55};
        bus(REGB + 32'h0, 4'hF, 32'h200, rd, n);
        bus(REGB + 32'h4, 4'hF, 32'd8, rd, n);
        bus(REGB + 32'h8, 4'hF, 32'h55, rd, n);
        b0 = busy_cyc;
        s0 = log_a.size();
        bus(REGB + 32'hC, 4'hF, 32'h1, rd, n);
        bus(BASE + 32'h300, 4'hF, 32'h04030201, rd, n);
        chk("cont_ack_within_8", {31'b0, n <= 8}, 32'd1);
        wait_idle();
        chk("cont_count", log_a.size() - s0, 12);
        for (int i = 0; i < 12; i++) begin
            chk("cont_addr", {16'b0, log_a[s0+i]}, {16'b0, exp_a[i]});
            chk("cont_data", {24'b0, log_d[s0+i]}, {24'b0, exp_d[i]});
        end
        chk("cont_busy_cycles", busy_cyc - b0, 12);
        bus(REGB + 32'h0, 4'hF, 32'h0, rd, n);
        bus(REGB + 32'h4, 4'hF, 32'd100, rd, n);
        bus(REGB + 32'hC, 4'hF, 32'h1, rd, n);
        repeat (3) step();
        chk("midfill_busy", {31'b0, fill_busy}, 1);
        rst = 1'b1;
        step();
        chk("rstfill_busy", {31'b0, fill_busy}, 0);
        chk("rstfill_fb_en", {31'b0, fb_en}, 0);
        s0 = log_a.size();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rstfill_nowrite", log_a.size() - s0, 0);
        bus(REGB + 32'hC, 4'h0, 32'h0, rd, n);
        chk("rstfill_status", rd, 0);
        bus(REGB + 32'h4, 4'h0, 32'h0, rd, n);
        chk("rstfill_len", rd, 0);
`else
        bus(REGB + 32'h4, 4'hF, 32'h5, rd, n);
        chk("nofill_wr_latency", n, 1);
        bus(REGB + 32'h4, 4'h0, 32'h0, rd, n);
        chk("nofill_len_rd", rd, 0);
        s0 = log_a.size();
        bus(REGB + 32'hC, 4'hF, 32'h1, rd, n);
        chk("nofill_busy", {31'b0, fill_busy}, 0);
        repeat (5) step();
        chk("nofill_nowrite", log_a.size() - s0, 0);
        bus(REGB + 32'hC, 4'h0, 32'h0, rd, n);
        chk("nofill_status", rd, 0);
`endif
        iomem_valid = 1'b1;
        iomem_addr = BASE + 32'h400;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h01020304;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("rststore_fb_en", {31'b0, fb_en}, 0);
        chk("rststore_ready", {31'b0, iomem_ready}, 0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        s0 = log_a.size();
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("rststore_nowrite", log_a.size() - s0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_ctrl.md
# vga_fb_ctrl

Framebuffer write controller for the 256x192, 8 bpp VGA framebuffer BRAM (49152 bytes). Sits between the picosoc iomem bus and write port A of the dual-port framebuffer. Port B is read by the scan-out logic. It serialises 32-bit CPU stores into byte writes and runs a hardware fill engine for clears and solid spans. CPU and fill engine share the single write port through a round-robin arbiter.

## Interface
Parameters:
- ADDR_BASE, 32'h0300_0000, base of the framebuffer byte window; control registers at ADDR_BASE + 32'h0001_0000
- FB_DEPTH, 49152, framebuffer size in bytes; byte addresses >= FB_DEPTH are out of range
- FB_AW, 16, framebuffer address width

Ports:
- clk  in  1  system clock; the only clock (already decided)
- rst  in  1  synchronous, active-high reset (already decided)
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte lane enables; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data, little-endian lanes
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- fb_en  out  1  BRAM port A enable
- fb_we  out  1  BRAM port A write enable
- fb_addr  out  FB_AW  BRAM byte address
- fb_din  out  8  BRAM write data
- fill_busy  out  1  fill engine running

## Operation
- Request decode happens only when iomem_valid=1 and no access is in progress. FB window: ADDR_BASE .. ADDR_BASE+FB_DEPTH-1. Register block: offsets 0x00–0x0C above ADDR_BASE+0x10000. Other addresses are not this block's (no ready).
- FB store: lanes with wstrb[i]=1 are written in ascending i order.
  - One lane per granted cycle, fb_addr = {word addr, i}, fb_din = wdata[8i+7:8i].
  - Lanes whose byte address >= FB_DEPTH are consumed without asserting fb_en.
- FB read: the window is write-only; rdata = 0.
- Registers (word access; unused bits read 0):
  - 0x00 FILL_ADDR[15:0]
  - 0x04 FILL_LEN[15:0] (byte count)
  - 0x08 FILL_COLOR[7:0]
  - 0x0C CMD/STATUS: write bit0=1 starts a fill; read bit0=busy, bit1=done (sticky, cleared by a write to 0x0C)
- Fill FSM:
  - IDLE: a start with FILL_LEN≠0 latches the address, count and colour, then goes to RUN. A start with FILL_LEN=0 sets done immediately. A start while in RUN is ignored.
  - RUN: each granted cycle writes colour at the current address, then increments the address and decrements the count. When the count reaches 0, or the next address would be >= FB_DEPTH (clamp, no wrap), it goes to IDLE and sets done.
- Arbiter:
  - Requesters are the CPU byte sequencer and the fill engine. A lone requester always wins.
  - When both request, the grant alternates using a last-grant bit (reset value = fill, so the CPU wins first). Fill cannot starve the CPU.
- Register writes to FILL_* during RUN update the registers only. The running fill uses its latched copies.

## Timing
- Reset values: iomem_ready=0, iomem_rdata=0, fb_en=0, fb_we=0, fb_addr=0, fb_din=0, fill_busy=0. The FSM is in IDLE, done=0, all registers are 0.
- fb_* outputs are registered. A granted byte appears on fb_* the cycle after the grant.
- Register access and FB read: iomem_ready asserts 1 cycle after valid is sampled.
- FB store with n enabled in-range lanes and no contention: ready asserts n cycles after valid. With wstrb≠0 but all lanes out of range, ready asserts after 1 cycle.
- Under contention each lane costs up to 2 cycles.
- fill_busy rises the cycle after the CMD write and falls the cycle after the last fill byte's grant. A fill of L bytes with no CPU traffic takes L cycles.
- Reset mid-fill or mid-store aborts immediately. No further fb_en is issued.

## Configuration
- VGA_FB_FILL_EN defined: the fill engine, FILL_* registers and arbiter are present.
- VGA_FB_FILL_EN undefined:
  - The CPU always owns the port and fill_busy is tied to 0.
  - Registers 0x00–0x0C read 0 and writes are acked and ignored.

## Structure
- Shared package vga_pkg holds:
  - FB_DEPTH, FB_AW and the register offsets (REG_FILL_ADDR, REG_FILL_LEN, REG_FILL_COLOR, REG_CMD)
  - the fill FSM state enum (ST_IDLE, ST_RUN)
- One sub-module, vga_fb_arb: 2-input round-robin grant with a last-grant register.

## Test plan
- Store wdata=32'hAABBCCDD, wstrb=4'hF to ADDR_BASE+0x100 -> writes 0x100=DD, 0x101=CC, 0x102=BB, 0x103=AA on consecutive cycles; ready 4 cycles after valid.
- Store wstrb=4'b0101 to ADDR_BASE+0xBFFC -> writes only 0xBFFC and 0xBFFE; ready after 2 cycles.
- FILL_ADDR=0x0010, FILL_LEN=5, COLOR=0x1C, CMD=1 -> bytes 0x10–0x14 = 0x1C; busy for 5 cycles; STATUS then reads 0x2.
- FILL_ADDR=0xBFFE, FILL_LEN=10 -> only 0xBFFE and 0xBFFF written; done set with no wrap to 0.
- CPU 4-byte store issued during a fill -> fb writes alternate CPU/fill; store acked within 8 cycles; fill completes with correct count.
- Assert rst during RUN -> fill_busy=0 and fb_en=0 from the next cycle; STATUS reads 0.
